// File: rtl/cnn_pkg.sv
// Shared CNN accelerator definitions: PE tile geometry and the OFM write-back FSM states.
package cnn_pkg;

    localparam int NUM_PE         = 16;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORDS_PER_VEC  = NUM_PE / BYTES_PER_WORD;
    localparam int K_W            = $clog2(WORDS_PER_VEC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAIN = 2'd2
    } wb_state_t;

endpackage

// File: rtl/ofm_vec_fifo.sv
// Small register FIFO holding whole 16-channel pixel vectors between the PE cluster and the word drain.
module ofm_vec_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/ofm_writeback.sv
// OFM write-back: buffers ReLU6 pixel vectors and writes them to BRAM four bytes per word,
// channel-fastest, so the next layer can read them as its IFM.
module ofm_writeback
    import cnn_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          OFM_W,
    input  logic [7:0]          OFM_C,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                valid_in,
    input  logic [NUM_PE*8-1:0] ofm_in,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output wb_state_t           state_dbg
);

    // Handshake: valid_in has no ready; a vector offered while the FIFO is full and not
    // popping in the same cycle is dropped and latched into the sticky overflow flag.

    localparam int              VEC_W  = NUM_PE * 8;
    localparam logic [K_W-1:0]  K_LAST = K_W'(WORDS_PER_VEC - 1);

    wb_state_t         state_q;
    wb_state_t         state_d;
    logic [K_W-1:0]    k_q;
    logic [7:0]        col_q;
    logic [7:0]        row_q;
    logic [7:0]        tile_q;
    logic [7:0]        w_last_q;
    logic [7:0]        tile_last_q;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] tile_ptr_q;
    logic [ADDR_W-1:0] pix_ptr_q;
    logic [VEC_W-1:0]  hold_q;
    logic [VEC_W-1:0]  src_vec;
    logic [VEC_W-1:0]  fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              arm;
    logic              push_req;
    logic              pop;
    logic              emit;
    logic              word_last;
    logic              layer_last;

    assign arm        = (state_q == IDLE) && start;
    assign push_req   = valid_in && (state_q != IDLE);
    assign layer_last = (col_q == w_last_q) && (row_q == w_last_q) && (tile_q == tile_last_q);
    assign busy       = (state_q != IDLE);
    assign state_dbg  = state_q;

    ofm_vec_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (VEC_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (arm),
        .push  (push_req),
        .pop   (pop),
        .din   (ofm_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Word 0 is taken straight from the FIFO head while the entry is popped into hold_q,
    // which frees the slot early enough to absorb three back-to-back vectors.
    always_comb begin
        state_d   = state_q;
        emit      = 1'b0;
        pop       = 1'b0;
        word_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!fifo_empty) begin
                    emit    = 1'b1;
                    pop     = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (k_q == '0) begin
                    if (!fifo_empty) begin
                        emit = 1'b1;
                        pop  = 1'b1;
                    end
                end else begin
                    emit = 1'b1;
                    if (k_q == K_LAST) begin
                        word_last = 1'b1;
                        if (layer_last) begin
                            state_d = IDLE;
                        end else if (fifo_empty) begin
                            state_d = ARMED;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign src_vec = pop ? fifo_dout : hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            k_q         <= '0;
            col_q       <= '0;
            row_q       <= '0;
            tile_q      <= '0;
            w_last_q    <= '0;
            tile_last_q <= '0;
            stride_q    <= '0;
            tile_ptr_q  <= '0;
            pix_ptr_q   <= '0;
            hold_q      <= '0;
        end else begin
            wr_en <= emit;
            done  <= word_last && layer_last;
            if (emit) begin
                wr_addr <= pix_ptr_q + ADDR_W'(k_q);
                wr_data <= src_vec[int'(k_q) * DATA_W +: DATA_W];
                k_q     <= k_q + K_W'(1);
            end
            if (pop) begin
                hold_q <= fifo_dout;
            end
            if (arm) begin
                w_last_q    <= OFM_W - 8'd1;
                tile_last_q <= (OFM_C >> 4) - 8'd1;
                stride_q    <= ADDR_W'(OFM_C >> 2);
                tile_ptr_q  <= base_addr;
                pix_ptr_q   <= base_addr;
                k_q         <= '0;
                col_q       <= '0;
                row_q       <= '0;
                tile_q      <= '0;
                overflow    <= 1'b0;
            end else begin
                if (push_req && fifo_full && !pop) begin
                    overflow <= 1'b1;
                end
                // Pixel pointer advances by one pixel's worth of words; a new tile restarts
                // from the tile pointer shifted by one vector's worth of words.
                if (word_last) begin
                    if (col_q == w_last_q) begin
                        col_q <= '0;
                        if (row_q == w_last_q) begin
                            row_q      <= '0;
                            tile_q     <= tile_q + 8'd1;
                            tile_ptr_q <= tile_ptr_q + ADDR_W'(WORDS_PER_VEC);
                            pix_ptr_q  <= tile_ptr_q + ADDR_W'(WORDS_PER_VEC);
                        end else begin
                            row_q     <= row_q + 8'd1;
                            pix_ptr_q <= pix_ptr_q + stride_q;
                        end
                    end else begin
                        col_q     <= col_q + 8'd1;
                        pix_ptr_q <= pix_ptr_q + stride_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ofm_writeback.sv
// Directed self-checking bench for ofm_writeback: layout, addressing, overflow, reset and wrap.
module tb_ofm_writeback;
    import cnn_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [7:0]   ofm_w;
    logic [7:0]   ofm_c;
    logic [31:0]  base_addr;
    logic         valid_in;
    logic [127:0] ofm_in;
    logic         wr_en;
    logic [31:0]  wr_addr;
    logic [31:0]  wr_data;
    logic         busy;
    logic         done;
    logic         overflow;
    wb_state_t    state_dbg;

    int n_vec;
    int n_err;
    int done_cnt;
    int done_at;
    logic [31:0] act_addr_q[$];
    logic [31:0] act_data_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    ofm_writeback dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .OFM_W     (ofm_w),
        .OFM_C     (ofm_c),
        .base_addr (base_addr),
        .valid_in  (valid_in),
        .ofm_in    (ofm_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // write monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                act_addr_q.push_back(wr_addr);
                act_data_q.push_back(wr_data);
            end
            if (done) begin
                done_cnt++;
                done_at = act_addr_q.size();
            end
        end
    end

    function automatic logic [127:0] vec_data(int v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'(16 * v + i);
        return r;
    endfunction

    // expected model: slot -> (pixel, tile) -> 4 words
    task automatic expect_vec(int w, int c, logic [31:0] base, int slot, int v);
        logic [127:0] d;
        int p;
        int t;
        d = vec_data(v);
        p = slot % (w * w);
        t = slot / (w * w);
        for (int k = 0; k < 4; k++) begin
            exp_addr_q.push_back(base + 32'(p * (c / 4) + t * 4 + k));
            exp_data_q.push_back(d[32*k +: 32]);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        act_addr_q.delete();
        act_data_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
        done_cnt = 0;
        done_at  = -1;
    endtask

    task automatic do_start(int w, int c, logic [31:0] base);
        ofm_w     = 8'(w);
        ofm_c     = 8'(c);
        base_addr = base;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic send_vec(int v);
        ofm_in   = vec_data(v);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
    endtask

    task automatic wait_idle(int budget, string name);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: busy still %b after %0d cycles, required 0", name, busy, budget);
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; valid_in = 1'b0; ofm_in = '0;
        ofm_w = 8'd0; ofm_c = 8'd0; base_addr = '0;
        repeat (3) step();
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset wr_en: got %b expected 0", wr_en); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b expected 0", done); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset overflow: got %b expected 0", overflow); end
        n_vec++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL reset state: got %0d expected IDLE", state_dbg); end
        rst_n = 1'b1;
        repeat (2) step();
        n_vec++; if (wr_en !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL post-reset idle: wr_en=%b busy=%b expected 0/0", wr_en, busy); end
    endtask

    task automatic test_single_tile();
        clear_sb();
        do_start(2, 16, 32'h100);
        n_vec++; if (state_dbg !== ARMED || busy !== 1'b1) begin n_err++; $display("FAIL t1 armed: state=%0d busy=%b expected ARMED/1", state_dbg, busy); end
        send_vec(0);
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL t1 latency capture edge: wr_en=%b expected 0", wr_en); end
        step();
        n_vec++; if (wr_en !== 1'b1 || wr_addr !== 32'h100 || wr_data !== 32'h03020100) begin
            n_err++; $display("FAIL t1 first word: wr_en=%b addr=%h data=%h expected 1/00000100/03020100", wr_en, wr_addr, wr_data);
        end
        repeat (4) step();
        for (int v = 1; v < 4; v++) begin
            send_vec(v);
            repeat (5) step();
        end
        wait_idle(20, "t1");
        for (int v = 0; v < 4; v++) expect_vec(2, 16, 32'h100, v, v);
        n_vec++; if (act_addr_q.size() != exp_addr_q.size()) begin n_err++; $display("FAIL t1 write count: got %0d expected %0d", act_addr_q.size(), exp_addr_q.size()); end
        for (int i = 0; i < exp_addr_q.size() && i < act_addr_q.size(); i++) begin
            n_vec++;
            if (act_addr_q[i] !== exp_addr_q[i] || act_data_q[i] !== exp_data_q[i]) begin
                n_err++; $display("FAIL t1 write %0d: got %h/%h expected %h/%h", i, act_addr_q[i], act_data_q[i], exp_addr_q[i], exp_data_q[i]);
            end
        end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL t1 done count: got %0d expected 1", done_cnt); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL t1 overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_two_tiles();
        clear_sb();
        do_start(1, 32, 32'h0);
        send_vec(10);
        repeat (3) step();
        send_vec(11);
        wait_idle(20, "t2");
        expect_vec(1, 32, 32'h0, 0, 10);
        expect_vec(1, 32, 32'h0, 1, 11);
        n_vec++; if (act_addr_q.size() != exp_addr_q.size()) begin n_err++; $display("FAIL t2 write count: got %0d expected %0d", act_addr_q.size(), exp_addr_q.size()); end
        for (int i = 0; i < exp_addr_q.size() && i < act_addr_q.size(); i++) begin
            n_vec++;
            if (act_addr_q[i] !== exp_addr_q[i] || act_data_q[i] !== exp_data_q[i]) begin
                n_err++; $display("FAIL t2 write %0d: got %h/%h expected %h/%h", i, act_addr_q[i], act_data_q[i], exp_addr_q[i], exp_data_q[i]);
            end
        end
        n_vec++; if (done_cnt != 1 || done_at != 8) begin n_err++; $display("FAIL t2 done: count=%0d at write %0d expected 1 at 8", done_cnt, done_at); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] dropped;
        int hits;
        clear_sb();
        do_start(2, 32, 32'h200);
        for (int v = 20; v < 23; v++) begin
            ofm_in = vec_data(v); valid_in = 1'b1; step();
        end
        valid_in = 1'b0;
        repeat (14) step();
        n_vec++; if (act_addr_q.size() != 12) begin n_err++; $display("FAIL t3 burst3 writes: got %0d expected 12", act_addr_q.size()); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL t3 burst3 overflow: got %b expected 0", overflow); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL t3 mid-layer busy: got %b expected 1", busy); end
        for (int v = 23; v < 27; v++) begin
            ofm_in = vec_data(v); valid_in = 1'b1; step();
        end
        valid_in = 1'b0;
        repeat (20) step();
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL t3 burst4 overflow: got %b expected 1", overflow); end
        send_vec(27);
        repeat (5) step();
        send_vec(28);
        wait_idle(20, "t3");
        for (int s = 0; s < 6; s++) expect_vec(2, 32, 32'h200, s, 20 + s);
        expect_vec(2, 32, 32'h200, 6, 27);
        expect_vec(2, 32, 32'h200, 7, 28);
        n_vec++; if (act_addr_q.size() != exp_addr_q.size()) begin n_err++; $display("FAIL t3 write count: got %0d expected %0d", act_addr_q.size(), exp_addr_q.size()); end
        for (int i = 0; i < exp_addr_q.size() && i < act_addr_q.size(); i++) begin
            n_vec++;
            if (act_addr_q[i] !== exp_addr_q[i] || act_data_q[i] !== exp_data_q[i]) begin
                n_err++; $display("FAIL t3 write %0d: got %h/%h expected %h/%h", i, act_addr_q[i], act_data_q[i], exp_addr_q[i], exp_data_q[i]);
            end
        end
        dropped = vec_data(26);
        hits = 0;
        foreach (act_data_q[i]) if (act_data_q[i] === dropped[31:0]) hits++;
        n_vec++; if (hits != 0) begin n_err++; $display("FAIL t3 dropped vector written: got %0d hits expected 0", hits); end
        n_vec++; if (done_cnt != 1 || overflow !== 1'b1) begin n_err++; $display("FAIL t3 end: done=%0d overflow=%b expected 1/1", done_cnt, overflow); end
    endtask

    task automatic test_reset_mid_layer();
        int n;
        clear_sb();
        do_start(2, 16, 32'h300);
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL t4 start clears overflow: got %b expected 0", overflow); end
        send_vec(30);
        repeat (5) step();
        send_vec(31);
        n = 0;
        while (act_addr_q.size() < 6 && n < 20) begin
            step();
            n++;
        end
        n_vec++; if (act_addr_q.size() != 6) begin n_err++; $display("FAIL t4 reach pixel1 word1: got %0d writes expected 6", act_addr_q.size()); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (wr_en !== 1'b0 || busy !== 1'b0 || state_dbg !== IDLE) begin
            n_err++; $display("FAIL t4 async reset: wr_en=%b busy=%b state=%0d expected 0/0/IDLE", wr_en, busy, state_dbg);
        end
        repeat (2) step();
        rst_n = 1'b1;
        step();
        clear_sb();
        do_start(2, 16, 32'h300);
        for (int v = 40; v < 44; v++) begin
            send_vec(v);
            repeat (4) step();
        end
        wait_idle(20, "t4");
        for (int v = 0; v < 4; v++) expect_vec(2, 16, 32'h300, v, 40 + v);
        n_vec++; if (act_addr_q.size() != exp_addr_q.size()) begin n_err++; $display("FAIL t4 write count: got %0d expected %0d", act_addr_q.size(), exp_addr_q.size()); end
        for (int i = 0; i < exp_addr_q.size() && i < act_addr_q.size(); i++) begin
            n_vec++;
            if (act_addr_q[i] !== exp_addr_q[i] || act_data_q[i] !== exp_data_q[i]) begin
                n_err++; $display("FAIL t4 write %0d: got %h/%h expected %h/%h", i, act_addr_q[i], act_data_q[i], exp_addr_q[i], exp_data_q[i]);
            end
        end
        n_vec++; if (done_cnt != 1 || overflow !== 1'b0) begin n_err++; $display("FAIL t4 end: done=%0d overflow=%b expected 1/0", done_cnt, overflow); end
    endtask

    task automatic test_idle_and_busy_start();
        clear_sb();
        ofm_in = vec_data(50);
        valid_in = 1'b1;
        repeat (4) step();
        valid_in = 1'b0;
        repeat (8) step();
        n_vec++; if (act_addr_q.size() != 0) begin n_err++; $display("FAIL t5 idle valid writes: got %0d expected 0", act_addr_q.size()); end
        n_vec++; if (state_dbg !== IDLE || busy !== 1'b0 || overflow !== 1'b0) begin
            n_err++; $display("FAIL t5 idle valid state: state=%0d busy=%b overflow=%b expected IDLE/0/0", state_dbg, busy, overflow);
        end
        do_start(1, 16, 32'h400);
        do_start(2, 16, 32'h500);
        n_vec++; if (state_dbg !== ARMED || act_addr_q.size() != 0) begin
            n_err++; $display("FAIL t5 busy start: state=%0d writes=%0d expected ARMED/0", state_dbg, act_addr_q.size());
        end
        send_vec(51);
        wait_idle(20, "t5");
        expect_vec(1, 16, 32'h400, 0, 51);
        n_vec++; if (act_addr_q.size() != exp_addr_q.size()) begin n_err++; $display("FAIL t5 write count: got %0d expected %0d", act_addr_q.size(), exp_addr_q.size()); end
        for (int i = 0; i < exp_addr_q.size() && i < act_addr_q.size(); i++) begin
            n_vec++;
            if (act_addr_q[i] !== exp_addr_q[i] || act_data_q[i] !== exp_data_q[i]) begin
                n_err++; $display("FAIL t5 write %0d: got %h/%h expected %h/%h", i, act_addr_q[i], act_data_q[i], exp_addr_q[i], exp_data_q[i]);
            end
        end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL t5 done count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_addr_wrap();
        clear_sb();
        do_start(3, 64, 32'hFFFF_FFF0);
        for (int v = 0; v < 36; v++) begin
            send_vec(60 + v);
            repeat (3) step();
        end
        wait_idle(40, "t6");
        for (int s = 0; s < 36; s++) expect_vec(3, 64, 32'hFFFF_FFF0, s, 60 + s);
        n_vec++; if (act_addr_q.size() != 144) begin n_err++; $display("FAIL t6 write count: got %0d expected 144", act_addr_q.size()); end
        for (int i = 0; i < exp_addr_q.size() && i < act_addr_q.size(); i++) begin
            n_vec++;
            if (act_addr_q[i] !== exp_addr_q[i] || act_data_q[i] !== exp_data_q[i]) begin
                n_err++; $display("FAIL t6 write %0d: got %h/%h expected %h/%h", i, act_addr_q[i], act_data_q[i], exp_addr_q[i], exp_data_q[i]);
            end
        end
        n_vec++; if (done_cnt != 1 || done_at != 144) begin n_err++; $display("FAIL t6 done: count=%0d at write %0d expected 1 at 144", done_cnt, done_at); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL t6 overflow: got %b expected 0", overflow); end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        done_cnt = 0;
        done_at  = -1;
        test_reset();
        test_single_tile();
        test_two_tiles();
        test_back_to_back();
        test_reset_mid_layer();
        test_idle_and_busy_start();
        test_addr_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
